// File: rtl/seg7_pkg.sv
// Shared 7-segment definitions: segment patterns, special codes, scan-slot helpers.
// Latency: n/a (constants and pure functions only).
// Backpressure: n/a.
package seg7_pkg;

    // Segment patterns, bit order {a,b,c,d,e,f,g}, active-high.
    localparam logic [6:0] SEG_0     = 7'h7E;
    localparam logic [6:0] SEG_1     = 7'h30;
    localparam logic [6:0] SEG_2     = 7'h6D;
    localparam logic [6:0] SEG_3     = 7'h79;
    localparam logic [6:0] SEG_4     = 7'h33;
    localparam logic [6:0] SEG_5     = 7'h5B;
    localparam logic [6:0] SEG_6     = 7'h5F;
    localparam logic [6:0] SEG_7     = 7'h70;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h7B;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    localparam logic [3:0] BLANK_CODE = 4'hF;
    localparam logic [3:0] ERR_CODE   = 4'hE;

    localparam int NUM_DIGITS = 6;

    // One sampled snapshot of the scan bus.
    typedef struct packed {
        logic [7:0] com;
        logic [6:0] seg;
        logic       dot;
    } scan_t;

    // Decoded pattern.
    typedef struct packed {
        logic [3:0] code;
        logic       is_blank;
        logic       is_err;
    } dec_t;

    // A scan slot is live when the unused selects are high and exactly one digit select is low.
    function automatic logic slot_valid(input logic [7:0] com);
        int n_low;
        n_low = 0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (!com[i]) n_low = n_low + 1;
        end
        return (com[7:6] == 2'b11) && (n_low == 1);
    endfunction

    // Index of the low select bit; only meaningful when slot_valid() holds.
    function automatic logic [2:0] slot_index(input logic [7:0] com);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (!com[i]) idx = 3'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational 7-segment pattern to BCD decoder with blank / invalid flags.
// Latency: 0 cycles (pure combinational).
// Backpressure: none.
//   seg in  [6:0] : segment pattern {a..g}
//   dec out dec_t : {code, is_blank, is_err}
module seg7_decode
    import seg7_pkg::*;
(
    input  logic [6:0] seg,
    output dec_t       dec
);

    always_comb begin
        dec = '{code: ERR_CODE, is_blank: 1'b0, is_err: 1'b1};
        case (seg)
            SEG_0:     dec = '{code: 4'd0, is_blank: 1'b0, is_err: 1'b0};
            SEG_1:     dec = '{code: 4'd1, is_blank: 1'b0, is_err: 1'b0};
            SEG_2:     dec = '{code: 4'd2, is_blank: 1'b0, is_err: 1'b0};
            SEG_3:     dec = '{code: 4'd3, is_blank: 1'b0, is_err: 1'b0};
            SEG_4:     dec = '{code: 4'd4, is_blank: 1'b0, is_err: 1'b0};
            SEG_5:     dec = '{code: 4'd5, is_blank: 1'b0, is_err: 1'b0};
            SEG_6:     dec = '{code: 4'd6, is_blank: 1'b0, is_err: 1'b0};
            SEG_7:     dec = '{code: 4'd7, is_blank: 1'b0, is_err: 1'b0};
            SEG_8:     dec = '{code: 4'd8, is_blank: 1'b0, is_err: 1'b0};
            SEG_9:     dec = '{code: 4'd9, is_blank: 1'b0, is_err: 1'b0};
            SEG_BLANK: dec = '{code: BLANK_CODE, is_blank: 1'b1, is_err: 1'b0};
            default:   dec = '{code: ERR_CODE, is_blank: 1'b0, is_err: 1'b1};
        endcase
    end

endmodule

// File: rtl/seg_scan_decoder.sv
// Scan-bus monitor: syncs com/seg/seg_dot, accepts settled slots, rebuilds HH:MM:SS frames.
// Latency: input change -> accept 2+SETTLE cycles; accept -> frame_valid 1 cycle.
// Backpressure: none; frames are strobed, outputs hold until the next complete frame.
//   clock, reset(active-low async) | com[7:0], seg[6:0], seg_dot, clr_err in
//   digits[23:0], blank_mask[5:0], dot_mask[5:0], frame_valid, decode_err, display_lost out
module seg_scan_decoder
    import seg7_pkg::*;
#(
    parameter int SETTLE  = 4,
    parameter int TIMEOUT = 200000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [7:0]  com,
    input  logic [6:0]  seg,
    input  logic        seg_dot,
    input  logic        clr_err,
    output logic [23:0] digits,
    output logic [5:0]  blank_mask,
    output logic [5:0]  dot_mask,
    output logic        frame_valid,
    output logic        decode_err,
    output logic        display_lost
);

    localparam int SW = $clog2(SETTLE + 1);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [SW-1:0] SETTLE_C  = SW'(SETTLE);
    localparam logic [SW-1:0] SETTLE_M1 = SW'(SETTLE - 1);
    localparam logic [TW-1:0] TIMEOUT_C = TW'(TIMEOUT);

    scan_t           sync1_q, sync1_d, sync2_q, sync2_d, prev_q, prev_d;
    logic [SW-1:0]   settle_q, settle_d;
    logic [TW-1:0]   to_q, to_d;
    logic [5:0][3:0] stage_dig_q, stage_dig_d;
    logic [5:0]      stage_blank_q, stage_blank_d;
    logic [5:0]      stage_dot_q, stage_dot_d;
    logic [5:0]      mask_q, mask_d;
    logic [5:0][3:0] digits_q, digits_d;
    logic [5:0]      blank_mask_q, blank_mask_d;
    logic [5:0]      dot_mask_q, dot_mask_d;
    logic            frame_valid_q, frame_valid_d;
    logic            decode_err_q, decode_err_d;
    logic            display_lost_q, display_lost_d;

    logic            cur_valid, changed, accept;
    logic [2:0]      slot;
    dec_t            dec;

    seg7_decode u_dec (
        .seg (sync2_q.seg),
        .dec (dec)
    );

    always_comb begin
        sync1_d        = '{com: com, seg: seg, dot: seg_dot};
        sync2_d        = sync1_q;
        prev_d         = sync2_q;
        settle_d       = settle_q;
        to_d           = to_q;
        stage_dig_d    = stage_dig_q;
        stage_blank_d  = stage_blank_q;
        stage_dot_d    = stage_dot_q;
        mask_d         = mask_q;
        digits_d       = digits_q;
        blank_mask_d   = blank_mask_q;
        dot_mask_d     = dot_mask_q;
        frame_valid_d  = 1'b0;
        display_lost_d = display_lost_q;
        accept         = 1'b0;

        cur_valid = slot_valid(sync2_q.com);
        slot      = slot_index(sync2_q.com);
        changed   = (sync2_q != prev_q);

        // Stability counter saturates at SETTLE so a held slot fires exactly once.
        if (!cur_valid) begin
            settle_d = '0;
        end else if (changed) begin
            settle_d = SW'(1);
            accept   = (SETTLE == 1);
        end else if (settle_q < SETTLE_C) begin
            settle_d = settle_q + 1'b1;
            accept   = (settle_q == SETTLE_M1);
        end

        if (accept) begin
            stage_dig_d[slot]   = dec.code;
            stage_blank_d[slot] = dec.is_blank;
            stage_dot_d[slot]   = sync2_q.dot;
            mask_d[slot]        = 1'b1;
            to_d                = '0;
            display_lost_d      = 1'b0;
        end else if (to_q != TIMEOUT_C) begin
            to_d = to_q + 1'b1;
        end

        // A stale partial frame is discarded once the display is declared lost.
        if (!accept && (to_d == TIMEOUT_C)) begin
            mask_d         = '0;
            display_lost_d = 1'b1;
        end

        // Publish straight from next-state staging so the completing digit is included.
        if (accept && (mask_d == 6'h3F)) begin
            frame_valid_d = 1'b1;
            digits_d      = stage_dig_d;
            blank_mask_d  = stage_blank_d;
            dot_mask_d    = stage_dot_d;
            mask_d        = '0;
        end

        // Set wins over a coincident clear.
        decode_err_d = (accept && dec.is_err) || (decode_err_q && !clr_err);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync1_q        <= '0;
            sync2_q        <= '0;
            prev_q         <= '0;
            settle_q       <= '0;
            to_q           <= '0;
            stage_dig_q    <= '0;
            stage_blank_q  <= '0;
            stage_dot_q    <= '0;
            mask_q         <= '0;
            digits_q       <= '0;
            blank_mask_q   <= '0;
            dot_mask_q     <= '0;
            frame_valid_q  <= 1'b0;
            decode_err_q   <= 1'b0;
            display_lost_q <= 1'b0;
        end else begin
            sync1_q        <= sync1_d;
            sync2_q        <= sync2_d;
            prev_q         <= prev_d;
            settle_q       <= settle_d;
            to_q           <= to_d;
            stage_dig_q    <= stage_dig_d;
            stage_blank_q  <= stage_blank_d;
            stage_dot_q    <= stage_dot_d;
            mask_q         <= mask_d;
            digits_q       <= digits_d;
            blank_mask_q   <= blank_mask_d;
            dot_mask_q     <= dot_mask_d;
            frame_valid_q  <= frame_valid_d;
            decode_err_q   <= decode_err_d;
            display_lost_q <= display_lost_d;
        end
    end

    assign digits       = digits_q;
    assign blank_mask   = blank_mask_q;
    assign dot_mask     = dot_mask_q;
    assign frame_valid  = frame_valid_q;
    assign decode_err   = decode_err_q;
    assign display_lost = display_lost_q;

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Bench for seg_scan_decoder: directed scan scenarios plus randomized scans vs a reference model.
// Latency: n/a.
// Backpressure: n/a.
module tb_seg_scan_decoder;

    localparam int SETTLE  = 4;
    localparam int TIMEOUT = 50;

    logic        clock;
    logic        reset;
    logic [7:0]  com;
    logic [6:0]  seg;
    logic        seg_dot;
    logic        clr_err;
    logic [23:0] digits;
    logic [5:0]  blank_mask;
    logic [5:0]  dot_mask;
    logic        frame_valid;
    logic        decode_err;
    logic        display_lost;

    seg_scan_decoder #(.SETTLE(SETTLE), .TIMEOUT(TIMEOUT)) dut (
        .clock        (clock),
        .reset        (reset),
        .com          (com),
        .seg          (seg),
        .seg_dot      (seg_dot),
        .clr_err      (clr_err),
        .digits       (digits),
        .blank_mask   (blank_mask),
        .dot_mask     (dot_mask),
        .frame_valid  (frame_valid),
        .decode_err   (decode_err),
        .display_lost (display_lost)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_bad = 0;
    int frames_seen = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [6:0]  pat_tbl [10] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33,
                                  7'h5B, 7'h5F, 7'h70, 7'h7F, 7'h7B};
    logic [15:0] m_s1, m_s2, m_prev;   // two-stage delay of {com,seg,dot}, then previous synced value
    int          m_run;                // length of the current run of identical synced values
    int          m_to;
    logic [3:0]  m_stage [6];
    bit          m_sblank [6], m_sdot [6], m_cap [6];
    logic [3:0]  m_dig [6];
    bit          m_blank [6], m_dot [6];
    bit          m_fv, m_err, m_lost;

    function automatic bit is_slot(input logic [7:0] c);
        return (c[7:6] == 2'b11) && ($countones(~c[5:0]) == 1);
    endfunction

    function automatic int slot_of(input logic [7:0] c);
        for (int i = 0; i < 6; i++) if (!c[i]) return i;
        return 0;
    endfunction

    task automatic model_reset();
        m_s1 = '0; m_s2 = '0; m_prev = '0; m_run = 0; m_to = 0;
        m_fv = 0; m_err = 0; m_lost = 0;
        for (int i = 0; i < 6; i++) begin
            m_stage[i] = 0; m_sblank[i] = 0; m_sdot[i] = 0; m_cap[i] = 0;
            m_dig[i] = 0; m_blank[i] = 0; m_dot[i] = 0;
        end
    endtask

    // Will the synced value now at the end of the pipeline be accepted on the next edge?
    function automatic bit accept_pending();
        int nr;
        if (!is_slot(m_s2[15:8])) return 0;
        nr = (m_s2 != m_prev) ? 1 : m_run + 1;
        return nr == SETTLE;
    endfunction

    task automatic model_step();
        logic [15:0] cur;
        bit acc, bad, all;
        int i;
        logic [6:0] p;
        cur = m_s2;
        acc = accept_pending();
        bad = 0;
        if (is_slot(cur[15:8])) m_run = (cur != m_prev) ? 1 : m_run + 1;
        else                    m_run = 0;
        m_fv = 0;
        if (acc) begin
            i = slot_of(cur[15:8]);
            p = cur[7:1];
            m_stage[i] = 4'hE; m_sblank[i] = 0; bad = 1;
            if (p == 7'h00) begin m_stage[i] = 4'hF; m_sblank[i] = 1; bad = 0; end
            for (int d = 0; d < 10; d++) if (p == pat_tbl[d]) begin m_stage[i] = 4'(d); bad = 0; end
            m_sdot[i] = cur[0];
            m_cap[i] = 1; m_to = 0; m_lost = 0;
            all = 1;
            for (int k = 0; k < 6; k++) all &= m_cap[k];
            if (all) begin
                m_fv = 1;
                for (int k = 0; k < 6; k++) begin
                    m_dig[k] = m_stage[k]; m_blank[k] = m_sblank[k]; m_dot[k] = m_sdot[k]; m_cap[k] = 0;
                end
            end
        end else begin
            if (m_to < TIMEOUT) m_to++;
            if (m_to == TIMEOUT) begin
                m_lost = 1;
                for (int k = 0; k < 6; k++) m_cap[k] = 0;
            end
        end
        m_err = bad || (m_err && !clr_err);
        m_prev = cur;
        m_s2 = m_s1;
        m_s1 = {com, seg, seg_dot};
    endtask

    task automatic compare_all();
        logic [23:0] ed;
        logic [5:0]  eb, eo;
        for (int i = 0; i < 6; i++) begin
            ed[i*4 +: 4] = m_dig[i]; eb[i] = m_blank[i]; eo[i] = m_dot[i];
        end
        chk("frame_valid", frame_valid, m_fv);
        chk("decode_err", decode_err, m_err);
        chk("display_lost", display_lost, m_lost);
        chk("digits", digits, ed);
        chk("blank_mask", blank_mask, eb);
        chk("dot_mask", dot_mask, eo);
    endtask

    // Inputs change only at negedge; model advances on the posedge, DUT is sampled at negedge.
    task automatic cycle();
        @(posedge clock);
        if (!reset) model_reset();
        else        model_step();
        @(negedge clock);
        compare_all();
        if (frame_valid) frames_seen++;
    endtask

    // clr_mode: 0 none, 1 pulse exactly on the accepting edge, 2 random pulses.
    task automatic drive(input logic [7:0] c, input logic [6:0] p, input logic d,
                         input int hold, input int gap, input int clr_mode);
        com = c; seg = p; seg_dot = d;
        for (int k = 0; k < hold + gap; k++) begin
            if (k == hold) com = 8'hFF;
            clr_err = (clr_mode == 1) ? accept_pending() :
                      (clr_mode == 2) ? ($urandom_range(0, 15) == 0) : 1'b0;
            cycle();
        end
        clr_err = 1'b0;
    endtask

    function automatic logic [7:0] sel(input int i);
        logic [7:0] one;
        one = 8'd1;
        return 8'hFF & ~(one << i);
    endfunction

    function automatic logic [41:0] pats_of(input logic [23:0] bcd);
        logic [41:0] r;
        for (int i = 0; i < 6; i++) r[i*7 +: 7] = pat_tbl[bcd[i*4 +: 4]];
        return r;
    endfunction

    // Scan com[5]..com[0]; slot 0 optionally pulses clr_err on its accept.
    task automatic scan_frame(input logic [41:0] pats, input logic [5:0] dots, input int clr0);
        for (int i = 5; i >= 0; i--)
            drive(sel(i), pats[i*7 +: 7], dots[i], 10, 2, (i == 0) ? clr0 : 0);
    endtask

    task automatic idle(input int n);
        com = 8'hFF;
        for (int k = 0; k < n; k++) cycle();
    endtask

    int f0;
    logic [41:0] pv;

    initial begin
        reset = 1'b1; com = 8'hFF; seg = '0; seg_dot = 1'b0; clr_err = 1'b0;
        model_reset();
        #1 reset = 1'b0;
        @(negedge clock);
        compare_all();
        repeat (2) cycle();
        reset = 1'b1;
        idle(3);

        // 1: clean scan of 12:34:56
        f0 = frames_seen;
        scan_frame(pats_of(24'h123456), 6'b0, 0);
        chk("t1_frames", frames_seen - f0, 1);
        chk("t1_digits", digits, 24'h123456);
        chk("t1_blank", blank_mask, 6'h00);
        chk("t1_dot", dot_mask, 6'h00);

        // 2: short glitch on com[2] between slots is ignored
        f0 = frames_seen;
        pv = pats_of(24'h123456);
        for (int i = 5; i >= 3; i--) drive(sel(i), pv[i*7 +: 7], 1'b0, 10, 2, 0);
        drive(sel(2), 7'h30, 1'b0, 3, 2, 0);
        for (int i = 2; i >= 0; i--) drive(sel(i), pv[i*7 +: 7], 1'b0, 10, 2, 0);
        chk("t2_frames", frames_seen - f0, 1);
        chk("t2_digits", digits, 24'h123456);

        // 3: blank on com[3], dot on com[1]
        pv = pats_of(24'h123456);
        pv[3*7 +: 7] = 7'h00;
        scan_frame(pv, 6'b000010, 0);
        chk("t3_digits", digits, 24'h12F456);
        chk("t3_blank", blank_mask, 6'b001000);
        chk("t3_dot", dot_mask, 6'b000010);

        // 4: invalid pattern on com[0], then clear, then clear coinciding with accept
        pv = pats_of(24'h123456);
        pv[6:0] = 7'h49;
        scan_frame(pv, 6'b0, 0);
        chk("t4_digit0", digits[3:0], 4'hE);
        chk("t4_err_set", decode_err, 1);
        clr_err = 1'b1; cycle(); clr_err = 1'b0; cycle();
        chk("t4_err_clr", decode_err, 0);
        scan_frame(pv, 6'b0, 1);
        chk("t4_err_set_wins", decode_err, 1);
        clr_err = 1'b1; cycle(); clr_err = 1'b0;

        // 5: loss of scan, then recovery
        idle(60);
        chk("t5_lost", display_lost, 1);
        chk("t5_digits_held", digits, 24'h12345E);
        f0 = frames_seen;
        pv = pats_of(24'h123456);
        for (int i = 5; i >= 0; i--) begin
            drive(sel(i), pv[i*7 +: 7], 1'b0, 10, 2, 0);
            if (i == 5) chk("t5_lost_clr", display_lost, 0);
        end
        chk("t5_frames", frames_seen - f0, 1);
        chk("t5_digits", digits, 24'h123456);

        // 6: reset mid-frame discards staged digits
        pv = pats_of(24'h999999);
        for (int i = 5; i >= 3; i--) drive(sel(i), pv[i*7 +: 7], 1'b1, 10, 2, 0);
        reset = 1'b0;
        #1;
        model_reset();
        chk("t6_rst_digits", digits, 0);
        chk("t6_rst_blank", blank_mask, 0);
        chk("t6_rst_dot", dot_mask, 0);
        chk("t6_rst_fv", frame_valid, 0);
        chk("t6_rst_err", decode_err, 0);
        chk("t6_rst_lost", display_lost, 0);
        idle(3);
        @(negedge clock);
        reset = 1'b1;
        compare_all();
        f0 = frames_seen;
        pv = pats_of(24'h000007);
        for (int i = 5; i >= 0; i--) begin
            drive(sel(i), pv[i*7 +: 7], 1'b0, 10, 2, 0);
            if (i == 1) chk("t6_no_early_frame", frames_seen - f0, 0);
        end
        chk("t6_frames", frames_seen - f0, 1);
        chk("t6_digits", digits, 24'h000007);

        // Randomized scans: short holds, out-of-order and double-select slots, blanks,
        // bad patterns, random clears and occasional display loss.
        for (int f = 0; f < 30; f++) begin
            for (int s = 5; s >= 0; s--) begin
                int idx, r;
                logic [7:0] c;
                logic [6:0] p;
                idx = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 5)) : s;
                c = sel(idx);
                if ($urandom_range(0, 19) == 0) c = c & sel(int'($urandom_range(0, 5)));
                r = int'($urandom_range(0, 19));
                p = (r == 0) ? 7'h00 : (r == 1) ? 7'($urandom) : pat_tbl[$urandom_range(0, 9)];
                drive(c, p, 1'($urandom), int'($urandom_range(1, 9)),
                      int'($urandom_range(0, 2)), 2);
            end
            if ($urandom_range(0, 7) == 0) idle(55);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
